// File: rtl/vertex_fetch_pkg.sv
// Shared definitions for the RAM vertex fetcher: FSM state encoding,
// coordinate field offsets and triangle grouping.
package vertex_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int VERTS_PER_TRI = 3;
  localparam int X_LSB         = 0;

  // y occupies the upper half of the RAM word
  function automatic int y_lsb(input int data_width);
    return data_width / 2;
  endfunction

endpackage

// File: rtl/coord_clamp.sv
// Combinational saturating clamp for one screen axis.
// Only compiled when VERTEX_FETCH_CLIP_EN is defined.
`ifdef VERTEX_FETCH_CLIP_EN
module coord_clamp #(
  parameter int          WIDTH = 16,
  parameter int unsigned LIMIT = 639
) (
  input  logic [WIDTH-1:0] coord,
  output logic [WIDTH-1:0] clamped
);

  // a limit wider than the field can never be exceeded
  localparam logic [WIDTH-1:0] MAX_VAL =
    (longint'(LIMIT) >= (longint'(1) << WIDTH)) ? '1 : WIDTH'(LIMIT);

  assign clamped = (coord > MAX_VAL) ? MAX_VAL : coord;

endmodule
`endif

// File: rtl/ram_vertex_fetcher.sv
// Walks the vertex RAM after the loader finishes and streams (x, y) vertices
// with triangle tags. Define VERTEX_FETCH_CLIP_EN to clamp to the screen.
module ram_vertex_fetcher
  import vertex_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_WORDS  = 10,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_done,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH/2-1:0] out_x,
  output logic [DATA_WIDTH/2-1:0] out_y,
  output logic [1:0]              out_vidx,
  output logic                    out_tri_last,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int Y_LSB = y_lsb(DATA_WIDTH);
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [1:0]            LAST_IDX = 2'(VERTS_PER_TRI - 1);

  generate
    if (NUM_WORDS < 1 || (DATA_WIDTH % 2) != 0 || SCREEN_W < 1 || SCREEN_H < 1 ||
        (longint'(BASE_ADDR) + longint'(NUM_WORDS) > (longint'(1) << ADDR_WIDTH)))
    begin : g_bad_params
      $error("ram_vertex_fetcher: illegal parameter combination");
    end
  endgenerate

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       tri_cnt;
  logic             armed;
  logic [HALF-1:0]  x_raw, y_raw, x_fld, y_fld;
  logic             trigger, handshake;

  assign x_raw     = ram_read_data[X_LSB +: HALF];
  assign y_raw     = ram_read_data[Y_LSB +: HALF];
  assign trigger   = (state == ST_IDLE) && load_done && armed;
  assign handshake = out_valid && out_ready;

`ifdef VERTEX_FETCH_CLIP_EN
  coord_clamp #(.WIDTH(HALF), .LIMIT(SCREEN_W - 1)) u_clamp_x (.coord(x_raw), .clamped(x_fld));
  coord_clamp #(.WIDTH(HALF), .LIMIT(SCREEN_H - 1)) u_clamp_y (.coord(y_raw), .clamped(y_fld));
`else
  assign x_fld = x_raw;
  assign y_fld = y_raw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (trigger) next_state = ST_ISSUE;
      ST_ISSUE:   next_state = ST_WAIT;
      ST_WAIT:    next_state = ST_PRESENT;
      ST_PRESENT: if (handshake) next_state = out_last ? ST_DONE : ST_ISSUE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // armed only re-arms on a sampled low, so a level held high gives one run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       armed <= 1'b1;
    else if (!load_done) armed <= 1'b1;
    else if (trigger)    armed <= 1'b0;
  end

  // The address register is loaded on entry to ISSUE so the RAM sees it
  // during ISSUE and its data lands while in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      tri_cnt       <= '0;
      ram_read_addr <= '0;
      out_valid     <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_vidx      <= '0;
      out_last      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            cnt           <= '0;
            tri_cnt       <= '0;
            ram_read_addr <= BASE;
          end
        end
        ST_WAIT: begin
          out_valid <= 1'b1;
          out_x     <= x_fld;
          out_y     <= y_fld;
          out_vidx  <= tri_cnt;
          out_last  <= (cnt == LAST_CNT);
        end
        ST_PRESENT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!out_last) begin
              cnt           <= cnt + 1'b1;
              tri_cnt       <= (tri_cnt == LAST_IDX) ? 2'd0 : tri_cnt + 2'd1;
              ram_read_addr <= BASE + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_tri_last = (out_vidx == LAST_IDX);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_ram_vertex_fetcher.sv
// Directed bench for ram_vertex_fetcher: three instances cover the default
// 10-word run, a 4-word partial triangle at BASE_ADDR=8 and a single word.
module tb_ram_vertex_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] mem [0:255];

  logic        load_done_a, out_ready_a, valid_a, tri_last_a, last_a, busy_a, done_a;
  logic [7:0]  addr_a;
  logic [31:0] rdata_a;
  logic [15:0] x_a, y_a;
  logic [1:0]  vidx_a;

  logic        load_done_b, out_ready_b, valid_b, tri_last_b, last_b, busy_b, done_b;
  logic [7:0]  addr_b;
  logic [31:0] rdata_b;
  logic [15:0] x_b, y_b;
  logic [1:0]  vidx_b;

  logic        load_done_c, out_ready_c, valid_c, tri_last_c, last_c, busy_c, done_c;
  logic [7:0]  addr_c;
  logic [31:0] rdata_c;
  logic [15:0] x_c, y_c;
  logic [1:0]  vidx_c;

  int checks = 0;
  int errors = 0;

`ifdef VERTEX_FETCH_CLIP_EN
  localparam logic [15:0] X11 = 16'd639;
  localparam logic [15:0] Y11 = 16'd479;
`else
  localparam logic [15:0] X11 = 16'd700;
  localparam logic [15:0] Y11 = 16'd900;
`endif

  ram_vertex_fetcher dut_a (
    .clk(clk), .reset_n(reset_n), .load_done(load_done_a), .ram_read_addr(addr_a),
    .ram_read_data(rdata_a), .out_valid(valid_a), .out_ready(out_ready_a), .out_x(x_a),
    .out_y(y_a), .out_vidx(vidx_a), .out_tri_last(tri_last_a), .out_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  ram_vertex_fetcher #(.BASE_ADDR(8), .NUM_WORDS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .load_done(load_done_b), .ram_read_addr(addr_b),
    .ram_read_data(rdata_b), .out_valid(valid_b), .out_ready(out_ready_b), .out_x(x_b),
    .out_y(y_b), .out_vidx(vidx_b), .out_tri_last(tri_last_b), .out_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  ram_vertex_fetcher #(.BASE_ADDR(5), .NUM_WORDS(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .load_done(load_done_c), .ram_read_addr(addr_c),
    .ram_read_data(rdata_c), .out_valid(valid_c), .out_ready(out_ready_c), .out_x(x_c),
    .out_y(y_c), .out_vidx(vidx_c), .out_tri_last(tri_last_c), .out_last(last_c),
    .busy(busy_c), .done(done_c)
  );

  // synchronous-read RAM: data valid one cycle after the address
  always @(posedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
    rdata_c <= mem[addr_c];
  end

  task automatic test_reset();
    reset_n = 1'b0;
    load_done_a = 0; load_done_b = 0; load_done_c = 0;
    out_ready_a = 1; out_ready_b = 1; out_ready_c = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_a, x_a, y_a, vidx_a, tri_last_a, last_a, busy_a, done_a, addr_a} !== 45'd0) begin
      errors++;
      $display("[TB] FAIL reset_a got v=%b x=%0d y=%0d vidx=%0d tl=%b l=%b busy=%b done=%b addr=%0d required all 0",
               valid_a, x_a, y_a, vidx_a, tri_last_a, last_a, busy_a, done_a, addr_a);
    end
    checks++;
    if (addr_b !== 8'd0 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b got addr=%0d v=%b busy=%b required 0 0 0", addr_b, valid_b, busy_b);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_trigger got busy=%b v=%b required 0 0", busy_a, valid_a);
    end
  endtask

  task automatic test_stream();
    int k = 0;
    int done_seen = 0;
    load_done_a = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_1 got v=%b busy=%b required v=0 busy=1", valid_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_2 got v=%b required 0", valid_a);
    end
    for (int cyc = 0; cyc < 100 && k < 10; cyc++) begin
      @(negedge clk);
      if (done_a) done_seen++;
      if (valid_a) begin
        checks++;
        if (cyc != 3 * k) begin
          errors++;
          $display("[TB] FAIL stream_timing k=%0d got cycle %0d required %0d", k, cyc, 3 * k);
        end
        checks++;
        if (x_a !== 16'(k) || y_a !== 16'(k + 100) || addr_a !== 8'(k)) begin
          errors++;
          $display("[TB] FAIL stream_xy k=%0d got x=%0d y=%0d addr=%0d required %0d %0d %0d",
                   k, x_a, y_a, addr_a, k, k + 100, k);
        end
        checks++;
        if (vidx_a !== 2'(k % 3) || tri_last_a !== (k % 3 == 2) || last_a !== (k == 9)) begin
          errors++;
          $display("[TB] FAIL stream_tags k=%0d got vidx=%0d tl=%b l=%b required %0d %b %b",
                   k, vidx_a, tri_last_a, last_a, k % 3, (k % 3 == 2), (k == 9));
        end
        k++;
      end
    end
    checks++;
    if (k != 10 || done_seen != 0) begin
      errors++;
      $display("[TB] FAIL stream_count got %0d vertices %0d early done required 10 0", k, done_seen);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse got done=%b busy=%b v=%b required 1 1 0", done_a, busy_a, valid_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_end got done=%b busy=%b required 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_no_retrigger();
    int active = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_a || busy_a) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("[TB] FAIL no_retrigger got %0d active cycles required 0", active);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    bit stalled = 0;
    int done_seen = 0;
    load_done_a = 1'b0;
    @(negedge clk);
    load_done_a = 1'b1;
    for (int cyc = 0; cyc < 150 && k < 10; cyc++) begin
      @(negedge clk);
      if (done_a) done_seen++;
      if (valid_a) begin
        if (k == 3 && !stalled) begin
          out_ready_a = 1'b0;
          stalled = 1;
          repeat (5) begin
            @(negedge clk);
            checks++;
            if (valid_a !== 1'b1 || x_a !== 16'd3 || y_a !== 16'd103 ||
                vidx_a !== 2'd0 || addr_a !== 8'd3) begin
              errors++;
              $display("[TB] FAIL stall_hold got v=%b x=%0d y=%0d vidx=%0d addr=%0d required 1 3 103 0 3",
                       valid_a, x_a, y_a, vidx_a, addr_a);
            end
          end
          out_ready_a = 1'b1;
        end
        checks++;
        if (x_a !== 16'(k) || y_a !== 16'(k + 100) || vidx_a !== 2'(k % 3) || last_a !== (k == 9)) begin
          errors++;
          $display("[TB] FAIL rerun_vertex k=%0d got x=%0d y=%0d vidx=%0d l=%b required %0d %0d %0d %b",
                   k, x_a, y_a, vidx_a, last_a, k, k + 100, k % 3, (k == 9));
        end
        k++;
      end
    end
    @(negedge clk);
    checks++;
    if (k != 10 || done_seen != 0 || done_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rerun_count got %0d vertices early=%0d done=%b required 10 0 1", k, done_seen, done_a);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found = 0;
    load_done_a = 1'b0;
    @(negedge clk);
    load_done_a = 1'b1;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (valid_a && x_a == 16'd4) begin
        found = 1;
        out_ready_a = 1'b0;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL midrun_reach got no vertex 4 required vertex 4 pending");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, x_a, y_a, vidx_a, tri_last_a, last_a, busy_a, done_a, addr_a} !== 45'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%b x=%0d y=%0d vidx=%0d busy=%b addr=%0d required all 0",
               valid_a, x_a, y_a, vidx_a, busy_a, addr_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready_a = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      if (valid_a) found = 1;
    end
    checks++;
    if (!found || x_a !== 16'd0 || y_a !== 16'd100 || addr_a !== 8'd0 || vidx_a !== 2'd0) begin
      errors++;
      $display("[TB] FAIL restart got found=%b x=%0d y=%0d addr=%0d vidx=%0d required 1 0 100 0 0",
               found, x_a, y_a, addr_a, vidx_a);
    end
    found = 0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (done_a) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL restart_done got no done pulse required one");
    end
  endtask

  task automatic test_partial_triangle();
    int k = 0;
    logic [15:0] ex, ey;
    load_done_b = 1'b1;
    for (int cyc = 0; cyc < 100 && k < 4; cyc++) begin
      @(negedge clk);
      if (valid_b) begin
        ex = (k == 3) ? X11 : 16'(8 + k);
        ey = (k == 3) ? Y11 : 16'(108 + k);
        checks++;
        if (x_b !== ex || y_b !== ey || addr_b !== 8'(8 + k)) begin
          errors++;
          $display("[TB] FAIL partial_xy k=%0d got x=%0d y=%0d addr=%0d required %0d %0d %0d",
                   k, x_b, y_b, addr_b, ex, ey, 8 + k);
        end
        checks++;
        if (vidx_b !== 2'(k % 3) || tri_last_b !== (k == 2) || last_b !== (k == 3)) begin
          errors++;
          $display("[TB] FAIL partial_tags k=%0d got vidx=%0d tl=%b l=%b required %0d %b %b",
                   k, vidx_b, tri_last_b, last_b, k % 3, (k == 2), (k == 3));
        end
        k++;
      end
    end
    @(negedge clk);
    checks++;
    if (k != 4 || done_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL partial_done got %0d vertices done=%b required 4 1", k, done_b);
    end
  endtask

  task automatic test_single_word();
    bit found = 0;
    load_done_c = 1'b1;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      if (valid_c) found = 1;
    end
    checks++;
    if (!found || x_c !== 16'd5 || y_c !== 16'd105 || vidx_c !== 2'd0 ||
        last_c !== 1'b1 || tri_last_c !== 1'b0 || addr_c !== 8'd5) begin
      errors++;
      $display("[TB] FAIL single_vertex got found=%b x=%0d y=%0d vidx=%0d l=%b tl=%b addr=%0d required 1 5 105 0 1 0 5",
               found, x_c, y_c, vidx_c, last_c, tri_last_c, addr_c);
    end
    @(negedge clk);
    checks++;
    if (done_c !== 1'b1 || valid_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done got done=%b v=%b required 1 0", done_c, valid_c);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {16'(a + 100), 16'(a)};
    mem[11] = {16'd900, 16'd700};
    test_reset();
    test_stream();
    test_no_retrigger();
    test_backpressure();
    test_reset_mid_run();
    test_partial_triangle();
    test_single_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_vertex_fetcher.md
Name: ram_vertex_fetcher

Overview:
- Read-side counterpart of the ROM-to-RAM loader.
- Once the loader reports completion, this block walks the vertex RAM through its read port and unpacks each 32-bit word into an (x, y) coordinate.
- It streams the vertices to the line/triangle rasterizer over a valid/ready handshake, tagging triangle boundaries and the final vertex.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 32, RAM word width. Must be even; x = low half, y = high half.
- BASE_ADDR, 0, first RAM address read.
- NUM_WORDS, 10, number of words fetched. Must be ≥1 and BASE_ADDR+NUM_WORDS ≤ 2^ADDR_WIDTH, else elaboration error.
- SCREEN_W, 640, clip width (only used with the optional feature).
- SCREEN_H, 480, clip height (only used with the optional feature).

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- load_done, in, 1: loader completion level; stays high while the RAM is valid.
- ram_read_addr, out, ADDR_WIDTH: RAM read address.
- ram_read_data, in, DATA_WIDTH: RAM read data, valid exactly 1 cycle after the address.
- out_valid, out, 1: vertex valid.
- out_ready, in, 1: rasterizer accepts the vertex.
- out_x, out, DATA_WIDTH/2: vertex x.
- out_y, out, DATA_WIDTH/2: vertex y.
- out_vidx, out, 2: vertex index within its triangle (0,1,2).
- out_tri_last, out, 1: high when out_vidx==2.
- out_last, out, 1: final vertex of the run.
- busy, out, 1: high from leaving IDLE until the cycle DONE is exited.
- done, out, 1: one-cycle pulse after the final handshake.

Behaviour:
- Reset (asynchronous, any state, including mid-run): state=IDLE; ram_read_addr=0; out_valid=0; out_x/out_y/out_vidx=0; out_tri_last=0; out_last=0; busy=0; done=0; word counter=0; armed=1.
- Trigger: load_done is edge-qualified through the armed flag.
  - IDLE with load_done=1 and armed=1 → ISSUE; clear armed.
  - armed re-sets only when load_done is sampled 0.
  - This gives one run per loader completion.
- States:
  - IDLE: as above.
  - ISSUE: drive ram_read_addr = BASE_ADDR + cnt → WAIT.
  - WAIT: register ram_read_data into the output register.
    - x = data[DATA_WIDTH/2-1:0], y = data[DATA_WIDTH-1:DATA_WIDTH/2].
    - Set out_valid=1, out_vidx = cnt mod 3, out_last = (cnt == NUM_WORDS-1).
    - → PRESENT.
  - PRESENT: hold all outputs stable while out_valid=1 and out_ready=0. On out_valid & out_ready:
    - drop out_valid;
    - if out_last → DONE;
    - else increment cnt → ISSUE.
  - DONE: done=1 for exactly one cycle → IDLE. busy=0 from the following cycle.
- Latency:
  - First out_valid appears 2 cycles after the trigger edge is sampled in IDLE.
  - Throughput: 1 vertex per 3 cycles with out_ready tied high.
- ram_read_addr holds its last issued value outside ISSUE. The RAM is read-only from this block.
- out_vidx wraps 2→0. out_tri_last = (out_vidx==2).
- NUM_WORDS not a multiple of 3: the trailing partial triangle is still emitted, out_last=1 on its last vertex, out_tri_last=0 there.
- NUM_WORDS=1: single vertex with out_vidx=0 and out_last=1.
- out_ready while out_valid=0 is ignored.
- load_done falling during a run does not abort the run; the run completes normally.
- cnt width is clog2(NUM_WORDS) with a minimum of 1 bit; it never wraps because it stops at NUM_WORDS-1.

Optional Feature:
- Macro: VERTEX_FETCH_CLIP_EN.
- Defined: in WAIT, x is clamped to SCREEN_W-1 and y to SCREEN_H-1 (unsigned compare) before registering. Clamped vertices are still emitted; out_vidx/out_last are unaffected.
- Undefined: raw fields pass through; SCREEN_W/SCREEN_H are unused.

Decomposition:
- Shared package vertex_fetch_pkg:
  - state encoding (IDLE, ISSUE, WAIT, PRESENT, DONE) as a 3-bit localparam set;
  - X_LSB/Y_LSB field-offset constants;
  - VERTS_PER_TRI = 3.
- One natural sub-module, coord_clamp: combinational per-axis saturating clamp, instantiated twice, only under VERTEX_FETCH_CLIP_EN.

Test Plan:
- Default params; RAM[i] = {16'(i+100), 16'(i)}; out_ready=1; load_done rises → 10 vertices.
  - x = 0..9, y = 100..109.
  - out_vidx = 0,1,2,0,1,2,0,1,2,0; out_tri_last on vertices 2, 5, 8.
  - out_last only on vertex 9; done pulses once, 1 cycle after its handshake.
- Backpressure: out_ready low for 5 cycles while vertex 3 is valid → out_x/out_y/out_vidx held constant, ram_read_addr unchanged, no vertex skipped or duplicated.
- load_done held high after a run → no second run. Drop load_done for 1 cycle, raise it again → a second identical 10-vertex run.
- Assert reset_n low while vertex 4 is pending → all outputs 0 asynchronously, state IDLE. After release with load_done=1 and armed=1, the run restarts from address BASE_ADDR.
- NUM_WORDS=4, BASE_ADDR=8 → addresses 8..11 read. out_vidx = 0,1,2,0; last vertex has out_last=1 and out_tri_last=0.
- With VERTEX_FETCH_CLIP_EN: RAM word {16'd900, 16'd700} → out_x=639, out_y=479. Without the macro → out_x=700, out_y=900.
